// File: rtl/key_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// key_debouncer_pkg
// Shared definitions for the push-button conditioning blocks.
//
// Contents
//   db_state_t : per-channel debounce state. The encoding is fixed so a
//                future switch debouncer can reuse the same state values.
//                bit[0] of a stable state equals the accepted level.
// -----------------------------------------------------------------------------
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,    // accepted level 0, input agrees
        PEND_HIGH   = 2'b01,    // accepted level 0, input has gone high, counting
        PEND_LOW    = 2'b10,    // accepted level 1, input has gone low, counting
        STABLE_HIGH = 2'b11     // accepted level 1, input agrees
    } db_state_t;

endpackage : key_debouncer_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button channel: two-flop synchroniser followed by a four-state
// debounce FSM with a stability counter. A new level is accepted only after
// DEBOUNCE_CYCLES consecutive synchronised samples disagree with the current
// accepted level; any reversal while counting drops back to the stable state.
//
// Ports
//   clock     in   system clock, all state updates on the rising edge
//   reset     in   asynchronous active-low reset
//   key_raw   in   raw pin, active-low (0 = pressed), asynchronous to clock
//   key_level out  debounced press level, active-high, registered
//
// Parameters
//   DEBOUNCE_CYCLES  stable samples needed to accept a change (>= 2)
//   CNT_WIDTH        counter width, wide enough for DEBOUNCE_CYCLES
// -----------------------------------------------------------------------------
module debounce_channel
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic key_level
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Synchroniser flops reset to 1, the released level of an active-low pin,
    // so a key held through reset is seen as a fresh press afterwards.
    logic sync1_reg;
    logic sync2_reg;

    db_state_t              state_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic                   level_reg;
    logic                   pressed;

    // Plain two-flop chain, nothing between the stages.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= key_raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign pressed = ~sync2_reg;

    // cnt_reg holds the number of consecutive disagreeing samples seen so far
    // in a PEND state. The change is accepted on the sample that would make it
    // DEBOUNCE_CYCLES, so the counter peaks at DEBOUNCE_CYCLES-1 and never wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= STABLE_LOW;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else begin
            case (state_reg)
                STABLE_LOW: begin
                    level_reg <= 1'b0;
                    if (pressed) begin
                        state_reg <= PEND_HIGH;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg   <= '0;
                    end
                end

                PEND_HIGH: begin
                    if (!pressed) begin
                        // bounce: drop the candidate, output untouched
                        state_reg <= STABLE_LOW;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= STABLE_HIGH;
                        level_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_ONE;
                    end
                end

                STABLE_HIGH: begin
                    level_reg <= 1'b1;
                    if (!pressed) begin
                        state_reg <= PEND_LOW;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg   <= '0;
                    end
                end

                PEND_LOW: begin
                    if (pressed) begin
                        state_reg <= STABLE_HIGH;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= STABLE_LOW;
                        level_reg <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_ONE;
                    end
                end

                default: begin
                    // recovery from a corrupted state register
                    state_reg <= STABLE_LOW;
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign key_level = level_reg;

endmodule : debounce_channel

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Front-end conditioning for the lock push-buttons. Each of NUM_KEYS raw,
// asynchronous, active-low pins is synchronised and debounced independently
// and presented as a clean active-high level for the rising-edge monitors.
// A clean pin change sampled at edge k shows on keyLevel at edge
// k + DEBOUNCE_CYCLES + 1.
//
// Ports
//   clock     in   system clock
//   reset     in   asynchronous active-low reset (keyLevel forced to 0)
//   keyRaw    in   [NUM_KEYS] raw pins, active-low (0 = pressed)
//   keyLevel  out  [NUM_KEYS] debounced level, active-high, registered
//
// Parameters
//   NUM_KEYS         number of independent channels
//   DEBOUNCE_CYCLES  stable samples needed to accept a change (>= 2)
// -----------------------------------------------------------------------------
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keyRaw,
    output logic [NUM_KEYS-1:0] keyLevel
);

    // Derived only; callers cannot override it.
    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);

    // Channels share nothing but clock and reset, so simultaneous presses
    // resolve with identical latency and no priority between keys.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_WIDTH       (CNT_WIDTH)
            ) u_chan (
                .clock     (clock),
                .reset     (reset),
                .key_raw   (keyRaw[gi]),
                .key_level (keyLevel[gi])
            );
        end
    endgenerate

endmodule : key_debouncer

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
// Directed stimulus for key_debouncer (NUM_KEYS=4, DEBOUNCE_CYCLES=8).
// The stimulus process pushes every expected keyLevel change (edge number and
// new vector) into a queue; the monitor pops an entry whenever keyLevel moves.
// Expected latency: pin change driven after edge n is sampled at n+1 and
// reaches keyLevel at edge n+10.
// -----------------------------------------------------------------------------
module tb_key_debouncer;

    localparam int NK = 4;
    localparam int DC = 8;

    typedef struct {
        int            edge_no;
        logic [NK-1:0] level;
    } sb_t;

    logic          clock;
    logic          reset;
    logic [NK-1:0] keyRaw;
    logic [NK-1:0] keyLevel;

    int  cyc;
    int  n_vec;
    int  n_fail;
    bit  mon_en;
    logic [NK-1:0] prev_level;
    sb_t sb_q[$];

    key_debouncer #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .keyRaw   (keyRaw),
        .keyLevel (keyLevel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    // Monitor: any keyLevel movement must match the head of the scoreboard.
    always @(negedge clock) begin
        if (mon_en && keyLevel !== prev_level) begin
            n_vec = n_vec + 1;
            if (sb_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_change edge=%0d got=%b prev=%b", cyc, keyLevel, prev_level);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.edge_no != cyc || e.level !== keyLevel) begin
                    n_fail = n_fail + 1;
                    $display("FAIL level_change edge=%0d got=%b required edge=%0d level=%b",
                             cyc, keyLevel, e.edge_no, e.level);
                end else begin
                    $display("ok   change edge=%0d level=%b", cyc, keyLevel);
                end
            end
            prev_level = keyLevel;
        end
    end

    task automatic push(input int e, input logic [NK-1:0] v);
        sb_t s;
        s.edge_no = e;
        s.level   = v;
        sb_q.push_back(s);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [NK-1:0] got, input logic [NK-1:0] req);
        n_vec = n_vec + 1;
        if (got !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s edge=%0d got=%b required=%b", name, cyc, got, req);
        end else begin
            $display("ok   %s edge=%0d level=%b", name, cyc, got);
        end
    endtask

    initial begin
        int n;
        n_vec      = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        prev_level = '0;
        keyRaw     = 4'b1111;
        reset      = 1'b1;
        #1 reset   = 1'b0;

        // 1: reset state and idle
        step(3);
        check("reset_hold", keyLevel, 4'b0000);
        reset  = 1'b1;
        mon_en = 1'b1;
        step(50);
        check("idle_50", keyLevel, 4'b0000);

        // 2: clean press / release on key 0
        n = cyc;
        keyRaw = 4'b1110;
        push(n + 10, 4'b0001);
        step(9);
        check("k0_before_rise", keyLevel, 4'b0000);
        step(1);
        check("k0_at_rise", keyLevel, 4'b0001);
        step(20);
        n = cyc;
        keyRaw = 4'b1111;
        push(n + 10, 4'b0000);
        step(20);

        // 3: key 1 bouncing every 3 cycles, then held low
        for (int s = 0; s < 5; s++) begin
            keyRaw[1] = (s % 2 == 1);
            step(3);
        end
        // last segment (low) began 3 cycles ago
        push(cyc - 3 + 10, 4'b0010);
        step(20);
        n = cyc;
        keyRaw = 4'b1111;
        push(n + 10, 4'b0000);
        step(20);

        // 4: key 2 pulses of DC-1 (rejected) and DC (passed)
        keyRaw = 4'b1011;
        step(DC - 1);
        keyRaw = 4'b1111;
        step(15);
        check("k2_short_pulse", keyLevel, 4'b0000);
        n = cyc;
        keyRaw = 4'b1011;
        push(n + 10, 4'b0100);
        push(n + 18, 4'b0000);
        step(DC);
        keyRaw = 4'b1111;
        step(20);

        // 5: all keys together, key 2 released early
        n = cyc;
        keyRaw = 4'b0000;
        push(n + 10, 4'b1011);
        step(4);
        keyRaw = 4'b0100;
        step(6);
        check("multi_rise", keyLevel, 4'b1011);
        step(14);
        n = cyc;
        keyRaw = 4'b1111;
        push(n + 10, 4'b0000);
        step(20);

        // 6a: reset while key 0 is pending (count at 5)
        n = cyc;
        keyRaw = 4'b1110;
        step(7);
        reset = 1'b0;
        #1;
        check("rst_mid_pend", keyLevel, 4'b0000);
        step(2);
        reset = 1'b1;
        n = cyc;
        push(n + 10, 4'b0001);
        step(9);
        check("post_rst_early", keyLevel, 4'b0000);
        step(6);

        // 6b: reset while key 0 is accepted and held
        @(posedge clock);
        #2;
        push(cyc, 4'b0000);
        reset = 1'b0;
        #1;
        check("rst_mid_hold", keyLevel, 4'b0000);
        step(2);
        reset = 1'b1;
        n = cyc;
        push(n + 10, 4'b0001);
        step(20);
        n = cyc;
        keyRaw = 4'b1111;
        push(n + 10, 4'b0000);
        step(20);
        check("final_idle", keyLevel, 4'b0000);

        // anything left in the scoreboard never happened
        while (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            n_vec  = n_vec + 1;
            n_fail = n_fail + 1;
            $display("FAIL missing_change got=none required edge=%0d level=%b", e.edge_no, e.level);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_key_debouncer
